// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: RV32 opcode field values (inst[6:2]),
// FSM state encoding, ALU operation codes and the decoded-opcode bundle.
package multicycle_control_unit_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
  } dec_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction/memory handshake inputs and datapath control outputs.
// master = instruction/memory side, slave = control unit.
interface multicycle_control_unit_if #(
  parameter int OPC_W = 5
);
  logic [OPC_W-1:0] opcode;
  logic             inst_valid;
  logic             mem_ready;

  logic             branch;
  logic             jump;
  logic             mem_read;
  logic             mem_to_reg;
  logic             mem_write;
  logic             alu_src;
  logic             reg_write;
  logic [1:0]       alu_op;
  logic             ir_write;
  logic             pc_write;
  logic             instr_done;
  logic             illegal;
  logic             mem_fault;

  modport master (
    output opcode, inst_valid, mem_ready,
    input  branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
           alu_op, ir_write, pc_write, instr_done, illegal, mem_fault
  );

  modport slave (
    input  opcode, inst_valid, mem_ready,
    output branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
           alu_op, ir_write, pc_write, instr_done, illegal, mem_fault
  );
endinterface

// File: rtl/multicycle_control_unit_rv_opcode_decoder.sv
// Purely combinational opcode classifier: legality, ALU op/source and instruction class.
module rv_opcode_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] i_opcode,
  output dec_t             o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OPC_W'(OPC_R): begin
        o_dec.legal  = 1'b1;
        o_dec.alu_op = ALU_R;
      end
      OPC_W'(OPC_OP_IMM): begin
        o_dec.legal   = 1'b1;
        o_dec.alu_op  = ALU_I;
        o_dec.alu_src = 1'b1;
      end
      OPC_W'(OPC_LOAD): begin
        o_dec.legal   = 1'b1;
        o_dec.alu_src = 1'b1;
        o_dec.is_load = 1'b1;
      end
      OPC_W'(OPC_STORE): begin
        o_dec.legal    = 1'b1;
        o_dec.alu_src  = 1'b1;
        o_dec.is_store = 1'b1;
      end
      OPC_W'(OPC_BRANCH): begin
        o_dec.legal     = 1'b1;
        o_dec.alu_op    = ALU_BR;
        o_dec.is_branch = 1'b1;
      end
      OPC_W'(OPC_JAL), OPC_W'(OPC_JALR): begin
        o_dec.legal   = 1'b1;
        o_dec.alu_src = 1'b1;
        o_dec.is_jump = 1'b1;
      end
      OPC_W'(OPC_LUI), OPC_W'(OPC_AUIPC): begin
        o_dec.legal   = 1'b1;
        o_dec.alu_src = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer for an RV32 datapath.
// Optional macro RV_MEM_TIMEOUT_EN adds a MEM wait counter that traps with mem_fault.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_unit_if.slave bus
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be within 1..255");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [OPC_W-1:0] r_opcode;
  logic             r_illegal;
  logic             w_timeout;
  dec_t             w_dec;

  rv_opcode_decoder #(.OPC_W(OPC_W)) u_dec (
    .i_opcode (r_opcode),
    .o_dec    (w_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode  <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == ST_FETCH && bus.inst_valid) r_opcode <= bus.opcode;
      if (r_state == ST_DECODE && !w_dec.legal)  r_illegal <= 1'b1;
    end
  end

`ifdef RV_MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_wait_cnt;
  logic       r_mem_fault;

  // Counts completed MEM cycles without mem_ready; a late mem_ready on the last cycle still wins.
  assign w_timeout = (r_state == ST_MEM) && !bus.mem_ready && (r_wait_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt  <= 8'd0;
      r_mem_fault <= 1'b0;
    end else begin
      if (r_state == ST_MEM && !bus.mem_ready) r_wait_cnt <= r_wait_cnt + 8'd1;
      else                                     r_wait_cnt <= 8'd0;
      if (w_timeout) r_mem_fault <= 1'b1;
    end
  end

  assign bus.mem_fault = r_mem_fault;
`else
  assign w_timeout     = 1'b0;
  assign bus.mem_fault = 1'b0;
`endif

  assign bus.illegal = r_illegal;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FETCH:  if (bus.inst_valid) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = w_dec.legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (w_dec.is_load || w_dec.is_store) w_state_nxt = ST_MEM;
        else if (w_dec.is_branch)            w_state_nxt = ST_FETCH;
        else                                 w_state_nxt = ST_WB;
      end
      ST_MEM: begin
        if (bus.mem_ready) w_state_nxt = w_dec.is_load ? ST_WB : ST_FETCH;
        else if (w_timeout) w_state_nxt = ST_TRAP;
      end
      ST_WB:   w_state_nxt = ST_FETCH;
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    bus.branch     = 1'b0;
    bus.jump       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.instr_done = 1'b0;
    unique case (r_state)
      ST_FETCH: bus.ir_write = bus.inst_valid;
      ST_EXEC: begin
        bus.alu_op  = w_dec.alu_op;
        bus.alu_src = w_dec.alu_src;
        bus.jump    = w_dec.is_jump;
        if (w_dec.is_branch) begin
          bus.branch     = 1'b1;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
        end
      end
      ST_MEM: begin
        bus.mem_read  = w_dec.is_load;
        bus.mem_write = w_dec.is_store;
        if (bus.mem_ready && w_dec.is_store) begin
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
        end
      end
      ST_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = w_dec.is_load;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPC_W, default 5, opcode width (inst[6:2]).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, max wait cycles for mem_ready (range 1..255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 opcode  in  OPC_W  instruction opcode; sampled only in FETCH when inst_valid=1.
REQ-006 inst_valid  in  1  fetched instruction available.
REQ-007 mem_ready  in  1  data memory completes current access.
REQ-008 branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  datapath controls.
REQ-009 alu_op  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type arith.
REQ-010 ir_write, pc_write  out  1  instruction-register load; PC update.
REQ-011 instr_done  out  1  one-cycle pulse on last cycle of each retired instruction.
REQ-012 illegal, mem_fault  out  1  sticky trap flags.

Function
REQ-013 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs decoded from state and latched opcode only.
REQ-014 FETCH: ir_write=inst_valid; on inst_valid latch opcode, go DECODE; else hold.
REQ-015 DECODE: legal opcode (R, I-arith, Load, Store, Branch, JAL, JALR, LUI, AUIPC) -> EXEC; any other -> TRAP with illegal=1.
REQ-016 EXEC: alu_op/alu_src per opcode (alu_src=1 except R-type and Branch); Load/Store -> MEM; Branch -> FETCH with branch=1, pc_write=1, instr_done=1; all others -> WB.
REQ-017 EXEC SHALL assert jump=1 for JAL/JALR.
REQ-018 MEM: mem_read=1 (Load) or mem_write=1 (Store) held every cycle until mem_ready=1; on mem_ready Load -> WB, Store -> FETCH with pc_write=1, instr_done=1.
REQ-019 mem_ready while not in MEM SHALL be ignored.
REQ-020 WB: reg_write=1, mem_to_reg=1 only for Load, pc_write=1, instr_done=1; -> FETCH.
REQ-021 TRAP: all controls 0, flags held; exit only by reset.
REQ-022 Latency: Branch 3 cycles, R/I/LUI/AUIPC/JAL/JALR 4, Store 4+wait, Load 5+wait (from inst_valid cycle inclusive).
REQ-023 No control output SHALL be X for any opcode value; unspecified outputs are 0.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force FETCH, clear latched opcode, wait counter, illegal, mem_fault; all outputs 0 next cycle.
REQ-025 Reset mid-instruction (including during MEM wait or TRAP) SHALL abandon it with no pc_write/instr_done pulse.

Configuration
REQ-026 Macro RV_MEM_TIMEOUT_EN: when defined, a wait counter increments each MEM cycle without mem_ready; reaching MEM_TIMEOUT cycles -> TRAP with mem_fault=1; mem_ready arriving on the final cycle wins (normal completion).
REQ-027 Without RV_MEM_TIMEOUT_EN: MEM waits indefinitely, no counter, mem_fault tied 0.

Structure
REQ-028 Opcode constants, state enum encoding, alu_op codes SHALL live in the shared defines package, extended from existing opcode defines.
REQ-029 Combinational opcode decode (legal, alu_op, alu_src, is_load/store/branch/jump) SHALL be sub-module rv_opcode_decoder; FSM and counter stay in top.

Verification
REQ-030 R-type 01100, inst_valid pulse -> ir_write cycle 1, alu_op=10 EXEC, reg_write=1 WB, instr_done cycle 4.
REQ-031 Load 00000, mem_ready after 3 wait cycles -> mem_read high 4 cycles, then WB with mem_to_reg=1, reg_write=1.
REQ-032 Branch 11000 -> branch=1, alu_op=01, pc_write=1, instr_done in EXEC, reg_write never 1.
REQ-033 Opcode 11111 -> TRAP, illegal=1 held 20 cycles with inst_valid=1; rst_n=0 one edge clears to FETCH.
REQ-034 RV_MEM_TIMEOUT_EN, MEM_TIMEOUT=4, Store, mem_ready never -> mem_fault=1 after 4 MEM cycles; variant with mem_ready on 4th cycle -> normal completion.
REQ-035 rst_n=0 during Load MEM wait -> next cycle FETCH, all outputs 0, no instr_done.
